// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan readback path: segment codes,
// active-low digit selects and the slot numbering used by the decoder.
package seg_pkg;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;

  localparam logic [7:0] SEL_S0    = 8'hFE;
  localparam logic [7:0] SEL_S1    = 8'hFD;
  localparam logic [7:0] SEL_M0    = 8'hFB;
  localparam logic [7:0] SEL_M1    = 8'hF7;
  localparam logic [7:0] SEL_H0    = 8'hEF;
  localparam logic [7:0] SEL_H1    = 8'hDF;
  localparam logic [7:0] SEL_BLANK = 8'hFF;

  localparam logic [16:0] SEC_PER_DAY_M1 = 17'd86399;

  typedef enum logic [2:0] {
    SLOT_S0 = 3'd0,
    SLOT_S1 = 3'd1,
    SLOT_M0 = 3'd2,
    SLOT_M1 = 3'd3,
    SLOT_H0 = 3'd4,
    SLOT_H1 = 3'd5
  } slot_e;

  typedef struct packed {
    logic  legal;
    slot_e slot;
  } sel_dec_t;

  function automatic sel_dec_t sel_decode(input logic [7:0] sel);
    sel_dec_t r;
    r.legal = 1'b1;
    r.slot  = SLOT_S0;
    case (sel)
      SEL_S0:  r.slot = SLOT_S0;
      SEL_S1:  r.slot = SLOT_S1;
      SEL_M0:  r.slot = SLOT_M0;
      SEL_M1:  r.slot = SLOT_M1;
      SEL_H0:  r.slot = SLOT_H0;
      SEL_H1:  r.slot = SLOT_H1;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_decode_digit.sv
// Inverse of the display encoder: maps an active-low segment pattern back
// to a BCD digit, flagging any pattern the encoder can never produce.
module seg_decode_digit
  import seg_pkg::*;
(
  input  logic [7:0] i_y,
  output logic       o_legal,
  output logic [3:0] o_digit
);

  always_comb begin
    o_legal = 1'b1;
    o_digit = 4'd0;
    case (i_y)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Display-bus readback: synchronizes and debounces the (select, y) pair,
// assembles six digits into a checked time of day and seconds-of-day count.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [7:0]  select,
  input  logic [7:0]  y,
  output logic [3:0]  s0,
  output logic [3:0]  s1,
  output logic [3:0]  m0,
  output logic [3:0]  m1,
  output logic [3:0]  h0,
  output logic [3:0]  h1,
  output logic [16:0] count,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        sel_err,
  output logic        range_err
);

  localparam logic [7:0] STABLE_Q = 8'(STABLE_CYCLES);

  logic [7:0]       r_sel_m, r_sel_s, r_sel_p;
  logic [7:0]       r_y_m, r_y_s, r_y_p;
  logic [7:0]       r_cnt;
  logic             r_armed;
  logic [5:0]       r_mask;
  logic [5:0][3:0]  r_stg;
  logic             r_sel_err, r_seg_err, r_range_err;
  logic             r_p1_vld, r_p2_vld, r_fv;
  logic [10:0]      r_p1_hm;
  logic [5:0]       r_p1_sec;
  logic [23:0]      r_p1_dig, r_p2_dig, r_out_dig;
  logic [16:0]      r_p2_cnt, r_count;

  logic             w_changed, w_accept, w_do;
  logic             w_dig_legal;
  logic [3:0]       w_dig;
  sel_dec_t         w_sel;
  logic             w_complete, w_range_ok;
  logic [6:0]       w_hours;
  logic [5:0]       w_min, w_sec;
  logic [10:0]      w_hm;

  seg_decode_digit u_dec (
    .i_y     (r_y_p),
    .o_legal (w_dig_legal),
    .o_digit (w_dig)
  );

  assign w_sel     = sel_decode(r_sel_p);
  assign w_changed = {r_sel_s, r_y_s} != {r_sel_p, r_y_p};
  // r_sel_p/r_y_p is the pair being counted; accept it once when it has
  // been seen STABLE_CYCLES times in a row.
  assign w_accept  = r_armed && (r_cnt == STABLE_Q);
  assign w_do      = w_accept && (r_sel_p != SEL_BLANK);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_m <= SEL_BLANK;
      r_sel_s <= SEL_BLANK;
      r_sel_p <= SEL_BLANK;
      r_y_m   <= 8'hFF;
      r_y_s   <= 8'hFF;
      r_y_p   <= 8'hFF;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_sel_m <= select;
      r_sel_s <= r_sel_m;
      r_sel_p <= r_sel_s;
      r_y_m   <= y;
      r_y_s   <= r_y_m;
      r_y_p   <= r_y_s;
      if (w_changed) begin
        r_cnt   <= 8'd1;
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != STABLE_Q) r_cnt <= r_cnt + 8'd1;
        if (w_accept) r_armed <= 1'b0;
      end
    end
  end

  // Frame check uses the incoming hours-tens digit directly, since it is
  // being written into staging in the same cycle.
  assign w_complete = (w_sel.slot == SLOT_H1) && (&r_mask[4:0]);
  assign w_hours    = 7'(w_dig) * 7'd10 + 7'(r_stg[4]);
  assign w_min      = 6'(r_stg[3]) * 6'd10 + 6'(r_stg[2]);
  assign w_sec      = 6'(r_stg[1]) * 6'd10 + 6'(r_stg[0]);
  assign w_hm       = 11'(w_hours[4:0]) * 11'd60 + 11'(w_min);
  assign w_range_ok = (r_stg[0] <= 4'd9) && (r_stg[1] <= 4'd5) &&
                      (r_stg[2] <= 4'd9) && (r_stg[3] <= 4'd5) &&
                      (r_stg[4] <= 4'd9) && (w_dig <= 4'd9) &&
                      (w_hours <= 7'd23);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err   <= 1'b0;
      r_seg_err   <= 1'b0;
      r_range_err <= 1'b0;
      r_mask      <= '0;
      r_stg       <= '0;
      r_p1_vld    <= 1'b0;
      r_p1_hm     <= '0;
      r_p1_sec    <= '0;
      r_p1_dig    <= '0;
    end else begin
      r_sel_err   <= 1'b0;
      r_seg_err   <= 1'b0;
      r_range_err <= 1'b0;
      r_p1_vld    <= 1'b0;
      if (w_do) begin
        if (!w_sel.legal) begin
          r_sel_err <= 1'b1;
          r_mask    <= '0;
        end else if (!w_dig_legal) begin
          r_seg_err <= 1'b1;
          r_mask    <= '0;
        end else begin
          r_stg[w_sel.slot] <= w_dig;
          if (w_complete) begin
            r_mask <= '0;
            if (w_range_ok) begin
              r_p1_vld <= 1'b1;
              r_p1_hm  <= w_hm;
              r_p1_sec <= w_sec;
              r_p1_dig <= {w_dig, r_stg[4:0]};
            end else begin
              r_range_err <= 1'b1;
            end
          end else begin
            r_mask[w_sel.slot] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_p2_vld  <= 1'b0;
      r_p2_cnt  <= '0;
      r_p2_dig  <= '0;
      r_fv      <= 1'b0;
      r_out_dig <= '0;
      r_count   <= '0;
    end else begin
      r_p2_vld <= r_p1_vld;
      if (r_p1_vld) begin
        r_p2_cnt <= 17'(r_p1_hm) * 17'd60 + 17'(r_p1_sec);
        r_p2_dig <= r_p1_dig;
      end
      r_fv <= r_p2_vld;
      if (r_p2_vld) begin
        r_out_dig <= r_p2_dig;
        r_count   <= r_p2_cnt;
      end
    end
  end

  assign s0          = r_out_dig[3:0];
  assign s1          = r_out_dig[7:4];
  assign m0          = r_out_dig[11:8];
  assign m1          = r_out_dig[15:12];
  assign h0          = r_out_dig[19:16];
  assign h1          = r_out_dig[23:20];
  assign count       = r_count;
  assign frame_valid = r_fv;
  assign seg_err     = r_seg_err;
  assign sel_err     = r_sel_err;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus randomized scans with
// glitches and illegal pairs, checked against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int STABLE = 16;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b1;
  logic [7:0]  select   = 8'hFF;
  logic [7:0]  y        = 8'hFF;
  logic [3:0]  s0, s1, m0, m1, h0, h1;
  logic [16:0] count;
  logic        frame_valid, seg_err, sel_err, range_err;

  always #5 clk_100M = ~clk_100M;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk_100M    (clk_100M),
    .rst_n       (rst_n),
    .select      (select),
    .y           (y),
    .s0          (s0),
    .s1          (s1),
    .m0          (m0),
    .m1          (m1),
    .h0          (h0),
    .h1          (h1),
    .count       (count),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .sel_err     (sel_err),
    .range_err   (range_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pulse monitor
  int cyc = 0;
  int n_fv = 0, n_seg = 0, n_sel = 0, n_rng = 0, n_multi = 0;
  int fv_cyc = 0, rng_cyc = 0;
  always @(posedge clk_100M) cyc++;
  always @(negedge clk_100M) begin
    if (frame_valid) begin n_fv++; fv_cyc = cyc; end
    if (seg_err) n_seg++;
    if (sel_err) n_sel++;
    if (range_err) begin n_rng++; rng_cyc = cyc; end
    if (int'(frame_valid) + int'(seg_err) + int'(sel_err) + int'(range_err) > 1) n_multi++;
  end

  // reference model
  logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                               8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
  logic [7:0] sel_tab [6]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
  int   m_stg [6];
  bit   m_mask [6];
  int   e_dig [6];
  int   e_cnt;
  int   e_fv = 0, e_seg = 0, e_sel = 0, e_rng = 0;
  logic [7:0] lp_sel, lp_y;
  int   run;
  bit   taken;
  int   h1_start;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_stg[i] = 0; m_mask[i] = 0; e_dig[i] = 0;
    end
    e_cnt = 0; lp_sel = 8'hFF; lp_y = 8'hFF; run = 0; taken = 0;
  endtask

  task automatic model_accept(input logic [7:0] sel, input logic [7:0] yv);
    int slot, d, hrs;
    bit all5, ok;
    if (sel == 8'hFF) return;
    slot = -1; d = -1;
    for (int i = 0; i < 6; i++) if (sel_tab[i] == sel) slot = i;
    for (int i = 0; i < 10; i++) if (seg_tab[i] == yv) d = i;
    if (slot < 0) begin
      e_sel++;
      for (int i = 0; i < 6; i++) m_mask[i] = 0;
    end else if (d < 0) begin
      e_seg++;
      for (int i = 0; i < 6; i++) m_mask[i] = 0;
    end else begin
      m_stg[slot] = d;
      all5 = 1;
      for (int i = 0; i < 5; i++) if (!m_mask[i]) all5 = 0;
      if (slot == 5 && all5) begin
        hrs = m_stg[5] * 10 + m_stg[4];
        ok  = (m_stg[1] <= 5) && (m_stg[3] <= 5) && (hrs <= 23);
        if (ok) begin
          e_fv++;
          for (int i = 0; i < 6; i++) e_dig[i] = m_stg[i];
          e_cnt = hrs * 3600 + (m_stg[3] * 10 + m_stg[2]) * 60 + m_stg[1] * 10 + m_stg[0];
        end else begin
          e_rng++;
        end
        for (int i = 0; i < 6; i++) m_mask[i] = 0;
      end else begin
        m_mask[slot] = 1;
      end
    end
  endtask

  // drive a pair for n cycles starting at a negedge
  task automatic drive(input logic [7:0] sel, input logic [7:0] yv, input int n);
    select = sel;
    y      = yv;
    if (sel == lp_sel && yv == lp_y) run += n;
    else begin lp_sel = sel; lp_y = yv; run = n; taken = 0; end
    if (!taken && run >= STABLE) begin
      taken = 1;
      model_accept(sel, yv);
    end
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic scan_slots(input int hh, input int mm, input int ss, input int per, input int lo);
    int d [6];
    d[0] = ss % 10; d[1] = ss / 10; d[2] = mm % 10;
    d[3] = mm / 10; d[4] = hh % 10; d[5] = hh / 10;
    for (int i = lo; i < 5; i++) drive(sel_tab[i], seg_tab[d[i]], per);
    h1_start = cyc;
    drive(sel_tab[5], seg_tab[d[5]], per);
    drive(8'hFF, 8'hFF, 30);
  endtask

  task automatic check_state(input string tag);
    logic [23:0] ex;
    for (int i = 0; i < 6; i++) ex[i*4 +: 4] = 4'(e_dig[i]);
    chk({tag, "_digits"}, 32'({h1, h0, m1, m0, s1, s0}), 32'(ex));
    chk({tag, "_count"}, 32'(count), 32'(e_cnt));
    chk({tag, "_n_frame_valid"}, n_fv, e_fv);
    chk({tag, "_n_seg_err"}, n_seg, e_seg);
    chk({tag, "_n_sel_err"}, n_sel, e_sel);
    chk({tag, "_n_range_err"}, n_rng, e_rng);
    chk({tag, "_overlap"}, n_multi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hh, mm, ss, per;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (40) begin
      @(negedge clk_100M);
      select = 8'($urandom);
      y      = 8'($urandom);
    end
    check_state("reset");
    select = 8'hFF; y = 8'hFF;
    @(negedge clk_100M);
    rst_n = 1'b1;

    scan_slots(12, 34, 56, 40, 0);
    check_state("t123456");
    chk("t123456_count_const", 32'(count), 45296);
    chk("t123456_fv_latency", fv_cyc - h1_start, 2 + STABLE + 3);

    scan_slots(23, 59, 59, 40, 0);
    check_state("t235959");
    chk("t235959_count_const", 32'(count), 86399);
    scan_slots(0, 0, 0, 40, 0);
    check_state("t000000");
    chk("t000000_count_const", 32'(count), 0);

    drive(8'hFE, 8'h9F, 20);
    drive(8'hFE, 8'h25, 5);
    drive(8'hFE, 8'h9F, 20);
    scan_slots(7, 45, 31, 30, 1);
    check_state("glitch");
    chk("glitch_s0", 32'(s0), 1);

    drive(8'hFE, 8'hFF, 40);
    scan_slots(9, 9, 9, 40, 1);
    check_state("segerr_partial");
    scan_slots(9, 9, 9, 40, 0);
    check_state("segerr_full");

    drive(8'h7F, 8'h03, 40);
    scan_slots(15, 30, 45, 40, 0);
    check_state("selerr");

    scan_slots(24, 0, 0, 40, 0);
    check_state("hours24");
    chk("hours24_rng_latency", rng_cyc - h1_start, 2 + STABLE + 1);

    // reset while a valid frame is one stage into the pipeline
    for (int i = 0; i < 5; i++) drive(sel_tab[i], seg_tab[1], 40);
    select = sel_tab[5]; y = seg_tab[1];
    repeat (2 + STABLE + 1) @(posedge clk_100M);
    #1 rst_n = 1'b0;
    select = 8'hFF; y = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_100M);
    check_state("rst_mid");
    scan_slots(11, 11, 11, 40, 0);
    check_state("after_rst");

    for (int it = 0; it < 25; it++) begin
      int d [6];
      hh  = $urandom_range(0, 29);
      mm  = $urandom_range(0, 59);
      ss  = $urandom_range(0, 59);
      d[0] = ss % 10; d[1] = ss / 10; d[2] = mm % 10;
      d[3] = mm / 10; d[4] = hh % 10; d[5] = hh / 10;
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 3) == 0)
          drive(sel_tab[i], seg_tab[$urandom_range(0, 9)], $urandom_range(1, STABLE - 1));
        if ($urandom_range(0, 7) == 0)
          drive(8'($urandom), 8'($urandom), STABLE + 2);
        per = $urandom_range(STABLE, STABLE + 14);
        drive(sel_tab[i], seg_tab[d[i]], per);
      end
      drive(8'hFF, 8'hFF, 30);
      check_state($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display bus driven by `digital_clock`. It samples the active-low digit `select` and segment `y` lines and debounces each (select, y) pair. It decodes the segment patterns back to BCD and reassembles the six digits into a validated time of day plus a seconds-of-day count (0–86399). It is used as a display-readback monitor in self-checking benches and as an on-chip display integrity checker.

## Interface
- `STABLE_CYCLES`, 16: consecutive identical `clk_100M` samples required before a (select, y) pair is accepted; legal range 2–255.
- `clk_100M`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `select`  in  8: digit enables, active low. Legal codes:
  - 8'hFE = seconds units; 8'hFD = seconds tens
  - 8'hFB = minutes units; 8'hF7 = minutes tens
  - 8'hEF = hours units; 8'hDF = hours tens
- `y`  in  8: segment lines, active low.
- `s0, s1, m0, m1, h0, h1`  out  4 each: last valid frame's digits.
- `count`  out  17: last valid frame as h*3600 + m*60 + s.
- `frame_valid`  out  1: one-cycle pulse when the digit outputs and `count` update.
- `seg_err`  out  1: one-cycle pulse when an accepted pair has a legal select but an illegal segment code.
- `sel_err`  out  1: one-cycle pulse when an accepted select is neither legal nor 8'hFF.
- `range_err`  out  1: one-cycle pulse when a complete frame fails the range check.

## Operation
- Segment code table (y → digit):
  - 03→0, 9F→1, 25→2, 0D→3, 99→4
  - 49→5, 41→6, 1F→7, 01→8, 09→9
  - All other values are illegal.
- Input stage:
  - `select` and `y` pass through a 2-flop synchronizer.
  - A stability counter resets to 1 whenever the synchronized pair differs from the previous sample.
  - When the counter reaches `STABLE_CYCLES`, the pair is accepted exactly once.
  - An `armed` flag blocks re-acceptance until the pair changes.
- Accept handling:
  - select = 8'hFF (blanking): ignored, no effect.
  - Illegal select: pulse `sel_err` and clear the slot mask.
  - Legal select with illegal y: pulse `seg_err` and clear the slot mask.
  - Legal select with legal y: write the digit into that slot's staging register and set its bit in the 6-bit slot mask.
- Frame completion:
  - Triggered when the hours-tens slot is accepted while the other five mask bits are set.
  - The staging digits are then range-checked: s1 ≤ 5, m1 ≤ 5, all digits ≤ 9, h1*10 + h0 ≤ 23.
  - Pass: run the count pipeline; outputs update together with the `frame_valid` pulse.
  - Fail: pulse `range_err`; outputs keep their prior values.
  - The mask clears after completion either way.
- Arithmetic: hours = h1*10 + h0 (5 bits), minutes and seconds 6 bits each; count = (hours*60 + minutes)*60 + seconds, 17 bits, no saturation needed.
- Reset values: every output 0; mask, staging registers, stability counter and pipeline all cleared; `armed` = 1.

## Timing
- Input-change to accept: 2 sync cycles + `STABLE_CYCLES`.
- Let T be the cycle in which hours-tens is accepted:
  - `range_err` pulses at T+1.
  - `frame_valid`, the digit outputs and `count` update at T+3: stage 1 range check + hours/minutes combine, stage 2 ×60 + seconds, stage 3 output register.
- Throughput: accepts are spaced at least `STABLE_CYCLES` apart, so the pipeline never overlaps itself; no backpressure.
- Same-slot re-accept after another slot: overwrites the staging digit; the mask bit stays set.
- `rst_n` asserted mid-pipeline: in-flight frame discarded, no `frame_valid` pulse.
- All error and valid pulses are exactly one cycle and mutually exclusive within any cycle.

## Structure
- Package `seg_pkg`, holding:
  - segment code constants `SEG_0`..`SEG_9`
  - select constants `SEL_S0`..`SEL_H1` and `SEL_BLANK`
  - `SEC_PER_DAY_M1` = 17'd86399
- One sub-module, `seg_decode_digit`: combinational, y[7:0] → {legal, digit[3:0]}, the inverse of the display encoder.
- Top level contains the synchronizer, stability counter, slot mask, range check and 3-stage count pipeline.

## Test plan
- Reset: hold `rst_n` = 0 with random bus activity → all outputs 0, no pulses.
- Scan 12:34:56, 40 cycles per slot, slots 0→5 → one `frame_valid` at T+3; s0=6, s1=5, m0=4, m1=3, h0=2, h1=1, `count` = 45296.
- Scan 23:59:59, then 00:00:00 → `count` = 86399, then 0, each with exactly one `frame_valid`.
- Glitch: hold select=FE, y=9F for 20 cycles, switch y to 25 for 5 cycles, return to 9F → only the stable pairs are accepted; no accept of 25 with `STABLE_CYCLES` = 16.
- Errors, each followed by an otherwise complete scan:
  - select=FE, y=FF → `seg_err`, no `frame_valid` this scan.
  - select=7F → `sel_err`.
  - hours 24 → `range_err`; `count` unchanged.
- Assert `rst_n` at T+1 of a valid frame → no `frame_valid`, outputs 0; the next full scan decodes normally.
